// File: rtl/cv32e40s_lsu_obi_arbiter.sv
// Two-to-one OBI data-port arbiter: round-robin address phase with grant lock,
// and an ID FIFO that routes in-order responses back to their requester.

package cv32e40s_obi_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [1:0]  memtype;
        logic [2:0]  prot;
        logic        dbg;
    } obi_data_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [4:0]  rchk;
    } obi_data_resp_t;

endpackage

module cv32e40s_lsu_obi_arbiter
    import cv32e40s_obi_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [1:0]            req_valid_i,
    input  obi_data_req_t [1:0]   req_trans_i,
    output logic [1:0]            req_ready_o,
    output logic [1:0]            req_rvalid_o,
    output obi_data_resp_t        req_resp_o,

    output logic                  valid_o,
    output obi_data_req_t         trans_o,
    input  logic                  ready_i,
    input  logic                  resp_valid_i,
    input  obi_data_resp_t        resp_i,

    output logic                  busy_o,
    output logic                  protocol_err_o
);

    localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t                 state_q;
    logic                   rr_last_q;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [PTR_WIDTH-1:0]   wr_ptr_q;
    logic [PTR_WIDTH-1:0]   rd_ptr_q;
    logic [DEPTH-1:0]       id_fifo_q;

    logic                   gnt_valid;
    logic                   gnt_id;
    logic                   full;
    logic                   accept;
    logic                   pop;
    logic                   head_id;

    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
        if (p == PTR_WIDTH'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_WIDTH'(1);
    endfunction

    // A locked grant ignores the other requester; from IDLE a tie goes to whoever was not served last.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = 1'b0;
        unique case (state_q)
            LOCK0: begin
                gnt_valid = req_valid_i[0];
                gnt_id    = 1'b0;
            end
            LOCK1: begin
                gnt_valid = req_valid_i[1];
                gnt_id    = 1'b1;
            end
            default: begin
                gnt_valid = |req_valid_i;
                if (&req_valid_i) begin
                    gnt_id = ~rr_last_q;
                end else begin
                    gnt_id = req_valid_i[1];
                end
            end
        endcase
    end

    assign full    = (cnt_q == CNT_WIDTH'(DEPTH));
    assign valid_o = gnt_valid && !full;
    assign accept  = valid_o && ready_i;
    assign trans_o = req_trans_i[gnt_id];

    assign req_ready_o[0] = ready_i && gnt_valid && !gnt_id && !full;
    assign req_ready_o[1] = ready_i && gnt_valid &&  gnt_id && !full;

    // A response with nothing outstanding is flagged and never pops the FIFO.
    assign pop            = resp_valid_i && (cnt_q != '0);
    assign head_id        = id_fifo_q[rd_ptr_q];
    assign req_rvalid_o   = {pop && head_id, pop && !head_id};
    assign protocol_err_o = resp_valid_i && (cnt_q == '0);
    assign req_resp_o     = resp_i;

    assign busy_o = (cnt_q != '0) || (|req_valid_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_last_q <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (gnt_valid) begin
                        if (accept) begin
                            rr_last_q <= gnt_id;
                        end else begin
                            state_q <= gnt_id ? LOCK1 : LOCK0;
                        end
                    end
                end
                LOCK0: begin
                    if (!req_valid_i[0]) begin
                        state_q <= IDLE;
                    end else if (accept) begin
                        state_q   <= IDLE;
                        rr_last_q <= 1'b0;
                    end
                end
                LOCK1: begin
                    if (!req_valid_i[1]) begin
                        state_q <= IDLE;
                    end else if (accept) begin
                        state_q   <= IDLE;
                        rr_last_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Accept needs !full, so a simultaneous push and pop never collide on the same slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            id_fifo_q <= '0;
        end else begin
            if (accept) begin
                id_fifo_q[wr_ptr_q] <= gnt_id;
                wr_ptr_q            <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            unique case ({accept, pop})
                2'b10:   cnt_q <= cnt_q + CNT_WIDTH'(1);
                2'b01:   cnt_q <= cnt_q - CNT_WIDTH'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: tb/tb_cv32e40s_lsu_obi_arbiter.sv
// Randomized and directed bench for cv32e40s_lsu_obi_arbiter against a
// queue-based model of arbitration, outstanding limit and response routing.

module tb_cv32e40s_lsu_obi_arbiter;
    import cv32e40s_obi_pkg::*;

    localparam int DEPTH = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [1:0]           req_valid = '0;
    obi_data_req_t [1:0]  req_trans = '0;
    logic [1:0]           req_ready;
    logic [1:0]           req_rvalid;
    obi_data_resp_t       req_resp;
    logic                 valid_o;
    obi_data_req_t        trans_o;
    logic                 ready = 1'b0;
    logic                 resp_valid = 1'b0;
    obi_data_resp_t       resp = '0;
    logic                 busy;
    logic                 protocol_err;

    int q[$];
    int lock_id = -1;
    int last_id = 1;
    int n_checks = 0;
    int n_fail = 0;

    cv32e40s_lsu_obi_arbiter #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid),
        .req_trans_i    (req_trans),
        .req_ready_o    (req_ready),
        .req_rvalid_o   (req_rvalid),
        .req_resp_o     (req_resp),
        .valid_o        (valid_o),
        .trans_o        (trans_o),
        .ready_i        (ready),
        .resp_valid_i   (resp_valid),
        .resp_i         (resp),
        .busy_o         (busy),
        .protocol_err_o (protocol_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic obi_data_req_t mk_trans(input logic [31:0] addr, input logic [31:0] wdata);
        obi_data_req_t t;
        t         = '0;
        t.addr    = addr;
        t.we      = wdata[0];
        t.be      = wdata[7:4];
        t.wdata   = wdata;
        t.memtype = addr[1:0];
        t.prot    = addr[4:2];
        t.dbg     = addr[5];
        return t;
    endfunction

    function automatic obi_data_resp_t mk_resp(input logic [31:0] rdata, input logic err, input logic [4:0] rchk);
        obi_data_resp_t r;
        r.rdata = rdata;
        r.err   = err;
        r.rchk  = rchk;
        return r;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst        = 1'b1;
        req_valid  = '0;
        ready      = 1'b0;
        resp_valid = 1'b0;
        #1;
        check("rst_valid",   128'(valid_o),      128'(0));
        check("rst_ready",   128'(req_ready),    128'(0));
        check("rst_rvalid",  128'(req_rvalid),   128'(0));
        check("rst_perr",    128'(protocol_err), 128'(0));
        check("rst_busy",    128'(busy),         128'(0));
        check("rst_cnt",     128'(dut.cnt_q),    128'(0));
        q.delete();
        lock_id = -1;
        last_id = 1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One bus cycle: drive, compare against the model, then advance the model as the clock edge will.
    task automatic step(input logic [1:0] v, input obi_data_req_t t0, input obi_data_req_t t1,
                        input logic rdy, input logic rv, input obi_data_resp_t r);
        int          owner;
        logic        gv;
        logic        full_m;
        logic        exp_valid;
        logic        acc;
        logic        pop_m;
        logic [1:0]  exp_ready;
        logic [1:0]  exp_rvalid;
        obi_data_req_t exp_trans;

        @(negedge clk);
        req_valid    = v;
        req_trans[0] = t0;
        req_trans[1] = t1;
        ready        = rdy;
        resp_valid   = rv;
        resp         = r;
        #1;

        owner = -1;
        if (lock_id >= 0) begin
            if (v[lock_id]) owner = lock_id;
        end else if (v == 2'b11) begin
            owner = 1 - last_id;
        end else if (v == 2'b01) begin
            owner = 0;
        end else if (v == 2'b10) begin
            owner = 1;
        end
        gv         = (owner >= 0);
        full_m     = (q.size() == DEPTH);
        exp_valid  = gv && !full_m;
        acc        = exp_valid && rdy;
        exp_ready  = (acc) ? (2'b01 << owner) : 2'b00;
        pop_m      = rv && (q.size() > 0);
        exp_rvalid = pop_m ? (2'b01 << q[0]) : 2'b00;

        check("valid_o",   128'(valid_o),      128'(exp_valid));
        check("req_ready", 128'(req_ready),    128'(exp_ready));
        check("rvalid",    128'(req_rvalid),   128'(exp_rvalid));
        check("perr",      128'(protocol_err), 128'(rv && (q.size() == 0)));
        check("busy",      128'(busy),         128'((q.size() != 0) || (v != 2'b00)));
        check("cnt",       128'(dut.cnt_q),    128'(q.size()));
        if (gv) begin
            exp_trans = (owner == 1) ? t1 : t0;
            check("trans_o", 128'(trans_o), 128'(exp_trans));
        end
        if (rv) begin
            check("resp", 128'(req_resp), 128'(r));
        end

        if (pop_m) void'(q.pop_front());
        if (acc) q.push_back(owner);
        if (gv && acc) begin
            lock_id = -1;
            last_id = owner;
        end else if (gv) begin
            lock_id = owner;
        end else begin
            lock_id = -1;
        end
    endtask

    initial begin
        obi_data_req_t  a0, a1, ra, rb;
        obi_data_resp_t rz, rd;

        a0 = mk_trans(32'h1000_0000, 32'h0000_00F1);
        a1 = mk_trans(32'h2000_0024, 32'h0000_0FF0);
        rz = '0;
        rd = mk_resp(32'h1234_5678, 1'b0, 5'h0A);

        apply_reset();

        // single transfer and its response
        step(2'b01, a0, a1, 1'b1, 1'b0, rz);
        step(2'b00, a0, a1, 1'b0, 1'b1, rd);

        // fairness with a response every cycle
        step(2'b11, a0, a1, 1'b1, 1'b0, rz);
        for (int i = 0; i < 3; i++) step(2'b11, a0, a1, 1'b1, 1'b1, mk_resp(32'hC0DE_0000 + i, 1'b0, 5'(i)));
        step(2'b00, a0, a1, 1'b0, 1'b1, rd);

        // lock on R1 while R0 raises valid
        step(2'b10, a0, a1, 1'b0, 1'b0, rz);
        step(2'b11, a0, a1, 1'b0, 1'b0, rz);
        step(2'b11, a0, a1, 1'b0, 1'b0, rz);
        step(2'b11, a0, a1, 1'b1, 1'b0, rz);
        step(2'b11, a0, a1, 1'b1, 1'b0, rz);
        step(2'b00, a0, a1, 1'b0, 1'b1, rd);
        step(2'b00, a0, a1, 1'b0, 1'b1, rd);

        // outstanding limit
        step(2'b01, a0, a1, 1'b1, 1'b0, rz);
        step(2'b01, a0, a1, 1'b1, 1'b0, rz);
        step(2'b01, a0, a1, 1'b1, 1'b0, rz);
        step(2'b01, a0, a1, 1'b1, 1'b1, rd);
        step(2'b01, a0, a1, 1'b1, 1'b1, rd);
        step(2'b00, a0, a1, 1'b0, 1'b1, rd);
        step(2'b00, a0, a1, 1'b0, 1'b1, rd);

        // response routing with err passthrough
        step(2'b10, a0, a1, 1'b1, 1'b0, rz);
        step(2'b01, a0, a1, 1'b1, 1'b0, rz);
        step(2'b00, a0, a1, 1'b0, 1'b1, mk_resp(32'hA5A5_0001, 1'b1, 5'h11));
        step(2'b00, a0, a1, 1'b0, 1'b1, mk_resp(32'hA5A5_0000, 1'b0, 5'h02));

        // stray response, then reset with two outstanding
        step(2'b00, a0, a1, 1'b0, 1'b1, rd);
        step(2'b11, a0, a1, 1'b1, 1'b0, rz);
        step(2'b11, a0, a1, 1'b1, 1'b0, rz);
        apply_reset();
        step(2'b00, a0, a1, 1'b0, 1'b1, rd);

        for (int i = 0; i < 400; i++) begin
            ra = mk_trans($urandom, $urandom);
            rb = mk_trans($urandom, $urandom);
            step(2'($urandom), ra, rb, ($urandom_range(3, 0) != 0), 1'($urandom),
                 mk_resp($urandom, 1'($urandom), 5'($urandom)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
